// File: rtl/inner_src_pkg.sv
// Shared definitions for the inner pattern source scheduler.
//   - state_t      : scheduler FSM encoding
//   - ERR_*        : err_code values reported on the err pulse
//   - desc_t       : packed descriptor {init, step, len, rep}, DESC_W bits
//   - desc_words() : number of 16-bit words described by a byte length
package inner_src_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_ARM    = 3'd4,
    ST_RUN    = 3'd5,
    ST_FLUSH  = 3'd6
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_BADLEN  = 2'd2;
  localparam logic [1:0] ERR_ABORT   = 2'd3;

  localparam int INIT_W  = 8;
  localparam int STEP_W  = 8;
  localparam int LEN_W   = 16;
  localparam int REP_W   = 8;
  localparam int DESC_W  = INIT_W + STEP_W + LEN_W + REP_W;
  localparam int WORDS_W = LEN_W - 1;

  // The source needs at least this many words so it can see inner_oe
  // drop before its burst ends.
  localparam logic [WORDS_W-1:0] MIN_WORDS = WORDS_W'(4);

  typedef struct packed {
    logic [INIT_W-1:0] init;
    logic [STEP_W-1:0] step;
    logic [LEN_W-1:0]  len;
    logic [REP_W-1:0]  rep;
  } desc_t;

  // Byte length to 16-bit word count; an odd trailing byte is dropped.
  function automatic logic [WORDS_W-1:0] desc_words(input logic [LEN_W-1:0] len);
    return len[LEN_W-1:1];
  endfunction

endpackage

// File: rtl/inner_src_desc_fifo.sv
// Synchronous descriptor queue, QDEPTH entries of W bits, first-word
// fall-through read port.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   push, wdata        : write request and data (ignored when full)
//   pop                : drop head entry (ignored when empty)
//   clear              : flush all entries; wins over push/pop
//   rdata              : head entry, valid while !empty
//   full, empty        : occupancy flags
module inner_src_desc_fifo
  import inner_src_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int W      = DESC_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(QDEPTH);

  logic [W-1:0]  mem [QDEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(QDEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/inner_src_sched.sv
// Descriptor-driven scheduler for the inner pattern source.
// Takes {init, step, len, rep} descriptors from the host, programs the
// source (update_flag), arms one burst per repeat (inner_oe), counts the
// generated 16-bit words (gen_en) and moves on to the next descriptor.
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   cmd_valid/cmd_ready, cmd_init/step/len/rep : descriptor push
//   abort                              : clear queue and flush the source
//   init_dat, step_dat, dat_length     : source configuration
//   update_flag, inner_oe              : source program strobe / burst arm
//   gen_en, fifo_full_h                : source word strobe / downstream almost-full
//   busy, desc_done, err, err_code     : status
//   word_cnt                           : words counted in the current burst
module inner_src_sched
  import inner_src_pkg::*;
#(
  parameter int QDEPTH  = 4,
  parameter int UPD_CYC = 3,
  parameter int TO_CYC  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_init,
  input  logic [7:0]  cmd_step,
  input  logic [15:0] cmd_len,
  input  logic [7:0]  cmd_rep,
  input  logic        abort,
  output logic [7:0]  init_dat,
  output logic [7:0]  step_dat,
  output logic [15:0] dat_length,
  output logic        update_flag,
  output logic        inner_oe,
  input  logic        gen_en,
  input  logic        fifo_full_h,
  output logic        busy,
  output logic        desc_done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] word_cnt
);

  localparam int PH_W = $clog2(UPD_CYC + 2);
  localparam int WD_W = $clog2(TO_CYC + 1);
  localparam logic [PH_W-1:0] PH_UPD_LAST    = PH_W'(UPD_CYC - 1);
  localparam logic [PH_W-1:0] PH_SETTLE_LAST = PH_W'(1);
  localparam logic [PH_W-1:0] PH_FLUSH_LAST  = PH_W'(UPD_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST        = WD_W'(TO_CYC - 1);

  // A repeat count of zero still runs one burst.
  function automatic logic [REP_W-1:0] clamp_rep(input logic [REP_W-1:0] rep);
    return (rep == '0) ? REP_W'(1) : rep;
  endfunction

  state_t             state, state_n;
  logic [PH_W-1:0]    phase_cnt, phase_n;
  logic [REP_W-1:0]   rep_cfg, rep_left, rep_n;
  logic [15:0]        wcnt_n;
  logic [WD_W-1:0]    wd_cnt, wd_n;
  logic               err_n, done_n;
  logic [1:0]         code_n;
  logic               latch, q_pop, q_clear, q_push;
  logic               q_full, q_empty;
  logic [DESC_W-1:0]  q_rdata;
  desc_t              q_head;
  desc_t              q_in;
  logic               abort_eff;
  logic               wd_expire;
  logic [WORDS_W-1:0] words;
  logic [15:0]        wcnt_inc;

  // abort is meaningless with nothing active or queued.
  assign abort_eff = abort && !(state == ST_IDLE && q_empty);
  assign cmd_ready = !q_full && !abort_eff;
  assign q_push    = cmd_valid && cmd_ready;
  assign q_in      = '{init: cmd_init, step: cmd_step, len: cmd_len, rep: cmd_rep};
  assign q_head    = desc_t'(q_rdata);

  assign words     = desc_words(dat_length);
  assign wcnt_inc  = word_cnt + 16'd1;
  assign wd_expire = !gen_en && !fifo_full_h && (wd_cnt == WD_LAST);

  assign update_flag = (state == ST_LOAD) ||
                       (state == ST_FLUSH && phase_cnt < PH_W'(UPD_CYC));
  assign inner_oe    = (state == ST_ARM);
  assign busy        = (state != ST_IDLE) || !q_empty;

  inner_src_desc_fifo #(
    .QDEPTH (QDEPTH),
    .W      (DESC_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (q_push),
    .pop   (q_pop),
    .clear (q_clear),
    .wdata (q_in),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty)
  );

  always_comb begin
    state_n = state;
    phase_n = phase_cnt;
    rep_n   = rep_left;
    wcnt_n  = word_cnt;
    wd_n    = wd_cnt;
    err_n   = 1'b0;
    done_n  = 1'b0;
    code_n  = err_code;
    latch   = 1'b0;
    q_pop   = 1'b0;
    q_clear = 1'b0;

    if (abort_eff) begin
      q_clear = 1'b1;
      err_n   = 1'b1;
      code_n  = ERR_ABORT;
      state_n = ST_FLUSH;
      phase_n = '0;
      wd_n    = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (!q_empty) begin
            latch   = 1'b1;
            q_pop   = 1'b1;
            state_n = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (words >= MIN_WORDS) begin
            rep_n   = clamp_rep(rep_cfg);
            phase_n = '0;
            state_n = ST_LOAD;
          end else begin
            err_n   = 1'b1;
            code_n  = ERR_BADLEN;
            state_n = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (phase_cnt == PH_UPD_LAST) begin
            phase_n = '0;
            state_n = ST_SETTLE;
          end else begin
            phase_n = phase_cnt + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (phase_cnt == PH_SETTLE_LAST) begin
            wcnt_n  = '0;
            wd_n    = '0;
            state_n = ST_ARM;
          end else begin
            phase_n = phase_cnt + 1'b1;
          end
        end
        ST_ARM, ST_RUN: begin
          if (gen_en) begin
            wd_n = '0;
            if (state == ST_ARM) begin
              wcnt_n  = 16'd1;
              state_n = ST_RUN;
            end else if (wcnt_inc == {1'b0, words}) begin
              if (rep_left > REP_W'(1)) begin
                // Source reloads init on its own between repeats.
                rep_n   = rep_left - 1'b1;
                wcnt_n  = '0;
                state_n = ST_ARM;
              end else begin
                rep_n   = '0;
                wcnt_n  = wcnt_inc;
                done_n  = 1'b1;
                state_n = ST_IDLE;
              end
            end else begin
              wcnt_n = wcnt_inc;
            end
          end else if (wd_expire) begin
            err_n   = 1'b1;
            code_n  = ERR_TIMEOUT;
            wd_n    = '0;
            phase_n = '0;
            state_n = ST_FLUSH;
          end else if (!fifo_full_h) begin
            wd_n = wd_cnt + 1'b1;
          end
        end
        ST_FLUSH: begin
          // update_flag for UPD_CYC cycles resets the source, then 2 quiet cycles.
          if (phase_cnt == PH_FLUSH_LAST) begin
            phase_n = '0;
            state_n = ST_IDLE;
          end else begin
            phase_n = phase_cnt + 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      phase_cnt  <= '0;
      rep_left   <= '0;
      rep_cfg    <= '0;
      word_cnt   <= '0;
      wd_cnt     <= '0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      desc_done  <= 1'b0;
      init_dat   <= '0;
      step_dat   <= '0;
      dat_length <= '0;
    end else begin
      state     <= state_n;
      phase_cnt <= phase_n;
      rep_left  <= rep_n;
      word_cnt  <= wcnt_n;
      wd_cnt    <= wd_n;
      err       <= err_n;
      err_code  <= code_n;
      desc_done <= done_n;
      // Source configuration holds from this CHECK until the next one.
      if (latch) begin
        init_dat   <= q_head.init;
        step_dat   <= q_head.step;
        dat_length <= q_head.len;
        rep_cfg    <= q_head.rep;
      end
    end
  end

endmodule

// File: tb/tb_inner_src_sched.sv
// Directed bench for inner_src_sched: a small source model answers
// inner_oe with dat_length/2 gen_en strobes; counters track the DUT
// output strobes so each scenario can compare deltas against hand values.
module tb_inner_src_sched;

  localparam int QDEPTH  = 4;
  localparam int UPD_CYC = 3;
  localparam int TO_CYC  = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_init = '0;
  logic [7:0]  cmd_step = '0;
  logic [15:0] cmd_len = '0;
  logic [7:0]  cmd_rep = '0;
  logic        abort = 1'b0;
  logic [7:0]  init_dat;
  logic [7:0]  step_dat;
  logic [15:0] dat_length;
  logic        update_flag;
  logic        inner_oe;
  logic        gen_en;
  logic        fifo_full_h = 1'b0;
  logic        busy;
  logic        desc_done;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] word_cnt;

  always #5 clk = ~clk;

  inner_src_sched #(
    .QDEPTH  (QDEPTH),
    .UPD_CYC (UPD_CYC),
    .TO_CYC  (TO_CYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_init    (cmd_init),
    .cmd_step    (cmd_step),
    .cmd_len     (cmd_len),
    .cmd_rep     (cmd_rep),
    .abort       (abort),
    .init_dat    (init_dat),
    .step_dat    (step_dat),
    .dat_length  (dat_length),
    .update_flag (update_flag),
    .inner_oe    (inner_oe),
    .gen_en      (gen_en),
    .fifo_full_h (fifo_full_h),
    .busy        (busy),
    .desc_done   (desc_done),
    .err         (err),
    .err_code    (err_code),
    .word_cnt    (word_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Source model
  logic src_auto = 1'b0;
  logic man_gen  = 1'b0;
  logic auto_gen = 1'b0;
  int   src_left = 0;
  assign gen_en = src_auto ? auto_gen : man_gen;

  always @(posedge clk) begin
    #2;
    if (src_auto) begin
      if (src_left == 0 && inner_oe) src_left = int'(dat_length[15:1]);
      if (src_left > 0) begin
        auto_gen = 1'b1;
        src_left--;
      end else begin
        auto_gen = 1'b0;
      end
    end else begin
      auto_gen = 1'b0;
      src_left = 0;
    end
  end

  // Output strobe counters
  int          upd_cycles = 0, oe_cycles = 0, arm_cnt = 0;
  int          done_cnt = 0, err_cnt = 0, gen_total = 0;
  logic        oe_prev = 1'b0;
  logic [15:0] done_len [8];
  logic [15:0] done_wc = '0;

  always @(negedge clk) begin
    if (update_flag) upd_cycles++;
    if (inner_oe) oe_cycles++;
    if (inner_oe && !oe_prev) arm_cnt++;
    oe_prev = inner_oe;
    if (desc_done) begin
      done_len[done_cnt % 8] = dat_length;
      done_wc = word_cnt;
      done_cnt++;
    end
    if (err) err_cnt++;
    if (gen_en) gen_total++;
  end

  int b_upd, b_oe, b_arm, b_done, b_err, b_gen;

  task automatic snap();
    b_upd = upd_cycles; b_oe = oe_cycles; b_arm = arm_cnt;
    b_done = done_cnt;  b_err = err_cnt;  b_gen = gen_total;
  endtask

  task automatic push_desc(input logic [7:0] i, input logic [7:0] s,
                           input logic [15:0] l, input logic [7:0] r);
    int k;
    cmd_init = i; cmd_step = s; cmd_len = l; cmd_rep = r; cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 400) begin
      @(posedge clk); #1; k++;
    end
    if (k >= 400) begin
      n_cmp++; n_bad++;
      $display("FAIL push_timeout: cmd_ready stayed %0b, required 1", cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 3000) begin
      @(posedge clk); #1; k++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_idle_timeout: busy=%0b required 0", name, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_oe(input string name);
    int k;
    k = 0;
    while (!inner_oe && k < 200) begin
      @(posedge clk); #1; k++;
    end
    n_cmp++;
    if (inner_oe !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_arm_timeout: inner_oe=%0b required 1", name, inner_oe);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready: got %0b required 1", cmd_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b required 0", busy); end
    n_cmp++; if ({update_flag, inner_oe, desc_done, err} !== 4'b0) begin n_bad++; $display("FAIL reset_strobes: got %b required 0000", {update_flag, inner_oe, desc_done, err}); end
    n_cmp++; if ({init_dat, step_dat, dat_length, word_cnt, err_code} !== 50'h0) begin n_bad++; $display("FAIL reset_data: got %h required 0", {init_dat, step_dat, dat_length, word_cnt, err_code}); end
  endtask

  task automatic test_single();
    snap();
    src_auto = 1'b1;
    push_desc(8'h10, 8'h01, 16'd16, 8'd1);
    wait_idle("single");
    n_cmp++; if (upd_cycles - b_upd != 3) begin n_bad++; $display("FAIL single_update_cycles: got %0d required 3", upd_cycles - b_upd); end
    n_cmp++; if (oe_cycles - b_oe != 1) begin n_bad++; $display("FAIL single_oe_cycles: got %0d required 1", oe_cycles - b_oe); end
    n_cmp++; if (gen_total - b_gen != 8) begin n_bad++; $display("FAIL single_words: got %0d required 8", gen_total - b_gen); end
    n_cmp++; if (done_cnt - b_done != 1) begin n_bad++; $display("FAIL single_done: got %0d required 1", done_cnt - b_done); end
    n_cmp++; if (done_wc !== 16'd8) begin n_bad++; $display("FAIL single_word_cnt: got %0d required 8", done_wc); end
    n_cmp++; if ({init_dat, step_dat, dat_length} !== {8'h10, 8'h01, 16'd16}) begin n_bad++; $display("FAIL single_cfg: got %h required 10010010", {init_dat, step_dat, dat_length}); end
    n_cmp++; if (err_cnt - b_err != 0) begin n_bad++; $display("FAIL single_err: got %0d required 0", err_cnt - b_err); end
  endtask

  task automatic test_repeat();
    snap();
    push_desc(8'h20, 8'h02, 16'd32, 8'd3);
    wait_idle("repeat");
    n_cmp++; if (arm_cnt - b_arm != 3) begin n_bad++; $display("FAIL repeat_arms: got %0d required 3", arm_cnt - b_arm); end
    n_cmp++; if (upd_cycles - b_upd != 3) begin n_bad++; $display("FAIL repeat_update_cycles: got %0d required 3", upd_cycles - b_upd); end
    n_cmp++; if (gen_total - b_gen != 48) begin n_bad++; $display("FAIL repeat_words: got %0d required 48", gen_total - b_gen); end
    n_cmp++; if (done_cnt - b_done != 1) begin n_bad++; $display("FAIL repeat_done: got %0d required 1", done_cnt - b_done); end
    n_cmp++; if (done_wc !== 16'd16) begin n_bad++; $display("FAIL repeat_word_cnt: got %0d required 16", done_wc); end
  endtask

  task automatic test_bad_len();
    snap();
    push_desc(8'h30, 8'h01, 16'd6, 8'd1);
    push_desc(8'h40, 8'h01, 16'd8, 8'd1);
    wait_idle("badlen");
    n_cmp++; if (err_cnt - b_err != 1) begin n_bad++; $display("FAIL badlen_err: got %0d required 1", err_cnt - b_err); end
    n_cmp++; if (err_code !== 2'd2) begin n_bad++; $display("FAIL badlen_code: got %0d required 2", err_code); end
    n_cmp++; if (upd_cycles - b_upd != 3) begin n_bad++; $display("FAIL badlen_update_cycles: got %0d required 3", upd_cycles - b_upd); end
    n_cmp++; if (gen_total - b_gen != 4) begin n_bad++; $display("FAIL badlen_words: got %0d required 4", gen_total - b_gen); end
    n_cmp++; if (done_cnt - b_done != 1) begin n_bad++; $display("FAIL badlen_done: got %0d required 1", done_cnt - b_done); end
  endtask

  task automatic test_back_to_back();
    int ready_seen;
    int k;
    logic [15:0] exp_len;
    src_auto = 1'b0;
    snap();
    push_desc(8'h50, 8'h01, 16'd8, 8'd1);
    wait_oe("fill");
    for (int d = 1; d <= 4; d++) push_desc(8'h50, 8'h01, 16'(8 + 2 * d), 8'd1);
    cmd_init = 8'h55; cmd_step = 8'h01; cmd_len = 16'd18; cmd_rep = 8'd1; cmd_valid = 1'b1;
    ready_seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (cmd_ready) ready_seen++;
      @(posedge clk); #1;
    end
    n_cmp++; if (ready_seen != 0) begin n_bad++; $display("FAIL fill_ready_low: ready seen %0d cycles, required 0", ready_seen); end
    src_auto = 1'b1;
    k = 0;
    while (!cmd_ready && k < 200) begin
      @(posedge clk); #1; k++;
    end
    n_cmp++; if (done_cnt - b_done != 1) begin n_bad++; $display("FAIL fill_ready_after_pop: done=%0d when ready rose, required 1", done_cnt - b_done); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_idle("fill");
    n_cmp++; if (done_cnt - b_done != 6) begin n_bad++; $display("FAIL fill_done: got %0d required 6", done_cnt - b_done); end
    for (int d = 0; d < 6; d++) begin
      exp_len = 16'(8 + 2 * d);
      n_cmp++;
      if (done_len[(b_done + d) % 8] !== exp_len) begin
        n_bad++;
        $display("FAIL fill_order_%0d: got len %0d required %0d", d, done_len[(b_done + d) % 8], exp_len);
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    src_auto = 1'b0;
    snap();
    push_desc(8'h60, 8'h01, 16'd8, 8'd1);
    push_desc(8'h61, 8'h01, 16'd10, 8'd1);
    wait_oe("timeout");
    fifo_full_h = 1'b1;
    repeat (5000) @(posedge clk);
    #1;
    n_cmp++; if (err_cnt - b_err != 0 || inner_oe !== 1'b1) begin n_bad++; $display("FAIL timeout_frozen: err=%0d oe=%0b required 0/1", err_cnt - b_err, inner_oe); end
    fifo_full_h = 1'b0;
    n = 0;
    while (!err && n < 1100) begin
      @(posedge clk); #1; n++;
    end
    n_cmp++; if (n != 1024) begin n_bad++; $display("FAIL timeout_cycles: got %0d required 1024", n); end
    n_cmp++; if (err_code !== 2'd1) begin n_bad++; $display("FAIL timeout_code: got %0d required 1", err_code); end
    n_cmp++; if (inner_oe !== 1'b0) begin n_bad++; $display("FAIL timeout_oe: got %0b required 0", inner_oe); end
    snap();
    wait_oe("timeout_next");
    n_cmp++; if (upd_cycles - b_upd != 6) begin n_bad++; $display("FAIL timeout_update_cycles: got %0d required 6", upd_cycles - b_upd); end
    n_cmp++; if (dat_length !== 16'd10) begin n_bad++; $display("FAIL timeout_next_desc: got len %0d required 10", dat_length); end
    src_auto = 1'b1;
    wait_idle("timeout");
    n_cmp++; if (done_cnt - b_done != 1) begin n_bad++; $display("FAIL timeout_next_done: got %0d required 1", done_cnt - b_done); end
  endtask

  task automatic test_abort();
    int n;
    src_auto = 1'b0;
    push_desc(8'h70, 8'h01, 16'd16, 8'd1);
    wait_oe("abort");
    push_desc(8'h71, 8'h01, 16'd10, 8'd1);
    push_desc(8'h72, 8'h01, 16'd12, 8'd1);
    man_gen = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    man_gen = 1'b0;
    n_cmp++; if (word_cnt !== 16'd3) begin n_bad++; $display("FAIL abort_pre_word_cnt: got %0d required 3", word_cnt); end
    abort = 1'b1;
    cmd_init = 8'h73; cmd_step = 8'h01; cmd_len = 16'd8; cmd_rep = 8'd1; cmd_valid = 1'b1;
    #1;
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL abort_cmd_ready: got %0b required 0", cmd_ready); end
    @(posedge clk); #1;
    abort = 1'b0;
    cmd_valid = 1'b0;
    snap();
    n_cmp++; if (err !== 1'b1 || err_code !== 2'd3) begin n_bad++; $display("FAIL abort_err: got err=%0b code=%0d required 1/3", err, err_code); end
    n_cmp++; if (inner_oe !== 1'b0 || update_flag !== 1'b1) begin n_bad++; $display("FAIL abort_flush: got oe=%0b upd=%0b required 0/1", inner_oe, update_flag); end
    n = 0;
    while (busy && n < 50) begin
      @(posedge clk); #1; n++;
    end
    n_cmp++; if (n != 5) begin n_bad++; $display("FAIL abort_flush_len: got %0d required 5", n); end
    repeat (20) @(posedge clk);
    #1;
    n_cmp++; if (upd_cycles - b_upd != 3) begin n_bad++; $display("FAIL abort_update_cycles: got %0d required 3", upd_cycles - b_upd); end
    n_cmp++; if (busy !== 1'b0 || arm_cnt - b_arm != 0) begin n_bad++; $display("FAIL abort_queue_empty: got busy=%0b arms=%0d required 0/0", busy, arm_cnt - b_arm); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeat();
    test_bad_len();
    test_back_to_back();
    test_timeout();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit, required completion");
    $fatal(1, "bench stopped");
  end

endmodule
